// File: rtl/connect_n_game_fsm.sv
// Connect-N game controller: column cursor, board storage, drop placement and a
// four-direction win scan. Optional turn timer is enabled by CONNECT_N_TURN_TIMER_EN.
module connect_n_game_fsm #(
  parameter int ROWS       = 6,
  parameter int COLS       = 7,
  parameter int WIN_LEN    = 4,
  parameter int TURN_TICKS = 50000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      move_left,
  input  logic                      move_right,
  input  logic                      move_made,
  input  logic                      restart,
  output logic [2:0]                state,
  output logic                      player_turn,
  output logic [$clog2(COLS)-1:0]   col_sel,
  output logic [2*ROWS*COLS-1:0]    board_flat,
  output logic [$clog2(ROWS)-1:0]   last_row,
  output logic [$clog2(COLS)-1:0]   last_col,
  output logic [1:0]                winner,
  output logic                      game_over,
  output logic                      draw,
  output logic                      invalid_move,
  output logic                      timeout
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = ROWS * COLS;
  localparam int MW    = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    PLAYER_TURN   = 3'd1,
    MAKE_MOVE     = 3'd2,
    CHECK_WIN     = 3'd3,
    SWITCH_PLAYER = 3'd4,
    GAME_OVER     = 3'd5
  } state_t;

  state_t          cur_state, state_next;
  logic [1:0]      board [ROWS][COLS];
  logic [MW-1:0]   move_count;
  logic [1:0]      dir, dir_next;
  logic [1:0]      piece, top_code, winner_next;
  logic [RW-1:0]   drop_row;
  logic [CW-1:0]   col_next;
  logic            player_next, draw_next, invalid_next, timeout_next;
  logic            drop_en, clear_game, win_found, expire;
  logic            pos_run, neg_run;
  int              dr, dc, line_len;

  assign state     = cur_state;
  assign game_over = (cur_state == GAME_OVER);
  assign piece     = player_turn ? 2'b10 : 2'b01;

  // Off-board coordinates read as empty, which clips the scan at the edges.
  function automatic logic [1:0] cell_at(input int r, input int c);
    cell_at = 2'b00;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        if (i == r && j == c) cell_at = board[i][j];
  endfunction

  always_comb begin
    board_flat = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board_flat[2*(r*COLS+c) +: 2] = board[r][c];
  end

  // Top cell of the cursor column decides fullness; the deepest empty row takes the drop.
  always_comb begin
    top_code = 2'b00;
    drop_row = '0;
    for (int c = 0; c < COLS; c++)
      if (CW'(c) == col_sel) top_code = board[0][c];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (CW'(c) == col_sel && board[r][c] == 2'b00) drop_row = RW'(r);
  end

  always_comb begin
    dr       = 0;
    dc       = 0;
    line_len = 0;
    pos_run  = 1'b1;
    neg_run  = 1'b1;
    case (dir)
      2'd0:    dc = 1;
      2'd1:    dr = 1;
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int k = 1; k < WIN_LEN; k++) begin
      if (pos_run && cell_at(int'(last_row) + k*dr, int'(last_col) + k*dc) == piece)
        line_len = line_len + 1;
      else
        pos_run = 1'b0;
      if (neg_run && cell_at(int'(last_row) - k*dr, int'(last_col) - k*dc) == piece)
        line_len = line_len + 1;
      else
        neg_run = 1'b0;
    end
    win_found = (line_len + 1 >= WIN_LEN);
  end

`ifdef CONNECT_N_TURN_TIMER_EN
  localparam int TW = $clog2(TURN_TICKS);
  logic [TW-1:0] tick_count;
  logic          turn_input;

  assign turn_input = move_left | move_right | move_made;
  assign expire     = (cur_state == PLAYER_TURN) && (tick_count == TW'(TURN_TICKS - 1));

  // Leaving PLAYER_TURN zeroes the count, so every entry starts a fresh turn.
  always_ff @(posedge clk) begin
    if (reset)
      tick_count <= '0;
    else if (cur_state == PLAYER_TURN && !turn_input && !expire)
      tick_count <= tick_count + TW'(1);
    else
      tick_count <= '0;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next   = cur_state;
    player_next  = player_turn;
    col_next     = col_sel;
    dir_next     = dir;
    winner_next  = winner;
    draw_next    = draw;
    invalid_next = 1'b0;
    timeout_next = 1'b0;
    drop_en      = 1'b0;
    clear_game   = 1'b0;
    case (cur_state)
      IDLE: state_next = PLAYER_TURN;
      PLAYER_TURN: begin
        if (move_made) begin
          if (top_code != 2'b00) invalid_next = 1'b1;
          else                   state_next   = MAKE_MOVE;
        end else if (move_left && !move_right) begin
          col_next = (col_sel == '0) ? CW'(COLS - 1) : col_sel - CW'(1);
        end else if (move_right && !move_left) begin
          col_next = (col_sel == CW'(COLS - 1)) ? '0 : col_sel + CW'(1);
        end else if (expire) begin
          timeout_next = 1'b1;
          state_next   = SWITCH_PLAYER;
        end
      end
      MAKE_MOVE: begin
        drop_en    = 1'b1;
        dir_next   = 2'd0;
        state_next = CHECK_WIN;
      end
      CHECK_WIN: begin
        if (win_found) begin
          winner_next = piece;
          state_next  = GAME_OVER;
        end else if (dir == 2'd3) begin
          if (move_count == MW'(CELLS)) begin
            draw_next  = 1'b1;
            state_next = GAME_OVER;
          end else begin
            state_next = SWITCH_PLAYER;
          end
        end else begin
          dir_next = dir + 2'd1;
        end
      end
      SWITCH_PLAYER: begin
        player_next = ~player_turn;
        state_next  = PLAYER_TURN;
      end
      GAME_OVER: begin
        if (restart) begin
          clear_game  = 1'b1;
          player_next = 1'b0;
          col_next    = '0;
          winner_next = 2'b00;
          draw_next   = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= IDLE;
      player_turn  <= 1'b0;
      col_sel      <= '0;
      last_row     <= '0;
      last_col     <= '0;
      winner       <= 2'b00;
      draw         <= 1'b0;
      invalid_move <= 1'b0;
      timeout      <= 1'b0;
      move_count   <= '0;
      dir          <= 2'd0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] <= 2'b00;
    end else begin
      cur_state    <= state_next;
      player_turn  <= player_next;
      col_sel      <= col_next;
      winner       <= winner_next;
      draw         <= draw_next;
      invalid_move <= invalid_next;
      timeout      <= timeout_next;
      dir          <= dir_next;
      if (drop_en) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (RW'(r) == drop_row && CW'(c) == col_sel) board[r][c] <= piece;
        last_row   <= drop_row;
        last_col   <= col_sel;
        move_count <= move_count + MW'(1);
      end
      if (clear_game) begin
        move_count <= '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            board[r][c] <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_connect_n_game_fsm.sv
// Directed bench for connect_n_game_fsm: a default 6x7 board plus a 2x3 board for the draw case.
module tb_connect_n_game_fsm;

  logic        clk, reset;
  logic        move_left, move_right, move_made, restart;
  logic [2:0]  state;
  logic        player_turn;
  logic [2:0]  col_sel;
  logic [83:0] board_flat;
  logic [2:0]  last_row, last_col;
  logic [1:0]  winner;
  logic        game_over, draw, invalid_move, timeout;

  logic        s_left, s_right, s_made, s_restart;
  logic [2:0]  s_state;
  logic        s_player;
  logic [1:0]  s_col;
  logic [11:0] s_board;
  logic [0:0]  s_last_row;
  logic [1:0]  s_last_col;
  logic [1:0]  s_winner;
  logic        s_game_over, s_draw, s_invalid, s_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  int mb [6][7];
  int cur, pm, scur;

  connect_n_game_fsm dut (
    .clk(clk), .reset(reset), .move_left(move_left), .move_right(move_right),
    .move_made(move_made), .restart(restart), .state(state), .player_turn(player_turn),
    .col_sel(col_sel), .board_flat(board_flat), .last_row(last_row), .last_col(last_col),
    .winner(winner), .game_over(game_over), .draw(draw), .invalid_move(invalid_move),
    .timeout(timeout)
  );

  connect_n_game_fsm #(.ROWS(2), .COLS(3), .WIN_LEN(3)) dut_small (
    .clk(clk), .reset(reset), .move_left(s_left), .move_right(s_right),
    .move_made(s_made), .restart(s_restart), .state(s_state), .player_turn(s_player),
    .col_sel(s_col), .board_flat(s_board), .last_row(s_last_row), .last_col(s_last_col),
    .winner(s_winner), .game_over(s_game_over), .draw(s_draw), .invalid_move(s_invalid),
    .timeout(s_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic m, input logic rs);
    move_left = l; move_right = r; move_made = m; restart = rs;
    tick();
    move_left = 0; move_right = 0; move_made = 0; restart = 0;
  endtask

  task automatic smallStimulus(input logic r, input logic m, input logic rs);
    s_right = r; s_made = m; s_restart = rs;
    tick();
    s_right = 0; s_made = 0; s_restart = 0;
  endtask

  function automatic logic [83:0] modelFlat();
    logic [83:0] f;
    f = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        f[2*(r*7+c) +: 2] = 2'(mb[r][c]);
    return f;
  endfunction

  task automatic clearModel();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        mb[r][c] = 0;
    cur = 0;
    pm = 0;
  endtask

  // Places the piece in the model, then follows the DUT back to PLAYER_TURN or GAME_OVER.
  task automatic finishDrop(input int col, input int exp_cw, input bit exp_sw);
    int row, cw, n;
    bit sw;
    row = -1; cw = 0; n = 0; sw = 0;
    for (int r = 0; r < 6; r++)
      if (mb[r][col] == 0) row = r;
    if (row >= 0) mb[row][col] = pm + 1;
    checkOutput("make_move_state", state, 2);
    while (!(state == 3'd1 || state == 3'd5) && n < 20) begin
      if (state == 3'd3) cw++;
      if (state == 3'd4) sw = 1;
      tick();
      n++;
    end
    checkOutput("settle_bound", n < 20, 1);
    checkOutput("check_win_cycles", cw, exp_cw);
    checkOutput("switch_seen", sw, exp_sw);
    checkOutput("board", board_flat, modelFlat());
    checkOutput("last_row", last_row, row);
    checkOutput("last_col", last_col, col);
    if (exp_sw) pm = 1 - pm;
    checkOutput("player", player_turn, pm);
    checkOutput("timeout", timeout, 0);
  endtask

  task automatic dropAt(input int col, input int exp_cw, input bit exp_sw);
    repeat ((col - cur + 7) % 7) applyStimulus(0, 1, 0, 0);
    cur = col;
    checkOutput("cursor", col_sel, col);
    applyStimulus(0, 0, 1, 0);
    finishDrop(col, exp_cw, exp_sw);
  endtask

  task automatic smallDrop(input int col, input int exp_state);
    int n;
    n = 0;
    repeat ((col - scur + 3) % 3) smallStimulus(1, 0, 0);
    scur = col;
    smallStimulus(0, 1, 0);
    while (!(s_state == 3'd1 || s_state == 3'd5) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("small_settle_bound", n < 20, 1);
    checkOutput("small_state", s_state, exp_state);
  endtask

  initial begin
    move_left = 0; move_right = 0; move_made = 0; restart = 0;
    s_left = 0; s_right = 0; s_made = 0; s_restart = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;

    checkOutput("reset_state", state, 0);
    checkOutput("reset_board", board_flat, 0);
    checkOutput("reset_col", col_sel, 0);
    checkOutput("reset_player", player_turn, 0);
    checkOutput("reset_winner", winner, 0);
    checkOutput("reset_flags", {game_over, draw, invalid_move, timeout}, 0);
    checkOutput("reset_small_state", s_state, 0);
    clearModel();
    scur = 0;
    tick();
    checkOutput("idle_exit", state, 1);

    // Cursor wrap and priority rules, with the first drop taken alongside move_right.
    applyStimulus(1, 0, 0, 0);
    checkOutput("left_wrap", col_sel, 6);
    applyStimulus(0, 1, 0, 0);
    checkOutput("right_wrap", col_sel, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("left_right_hold", col_sel, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("made_priority_col", col_sel, 0);
    finishDrop(0, 4, 1);

    // Vertical P1 win in column 0, caught on the second scan direction.
    dropAt(1, 4, 1);
    dropAt(0, 4, 1);
    dropAt(1, 4, 1);
    dropAt(0, 4, 1);
    dropAt(1, 4, 1);
    dropAt(0, 2, 0);
    checkOutput("vert_winner", winner, 2'b01);
    checkOutput("vert_game_over", game_over, 1);
    checkOutput("vert_state", state, 5);
    checkOutput("vert_draw", draw, 0);

    applyStimulus(1, 0, 1, 0);
    checkOutput("over_ignore_state", state, 5);
    checkOutput("over_ignore_col", col_sel, 0);
    checkOutput("over_ignore_board", board_flat, modelFlat());

    applyStimulus(0, 0, 0, 1);
    checkOutput("restart_state", state, 0);
    checkOutput("restart_board", board_flat, 0);
    checkOutput("restart_winner", winner, 0);
    checkOutput("restart_game_over", game_over, 0);
    clearModel();
    tick();
    checkOutput("restart_play", state, 1);

    // Fill column 3, then a seventh drop there must be rejected.
    repeat (6) dropAt(3, 4, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("full_invalid", invalid_move, 1);
    checkOutput("full_state", state, 1);
    checkOutput("full_board", board_flat, modelFlat());
    checkOutput("full_player", player_turn, pm);
    tick();
    checkOutput("full_invalid_pulse", invalid_move, 0);
    checkOutput("full_state_after", state, 1);

    // Reset lands in the middle of a win scan.
    repeat (4) applyStimulus(0, 1, 0, 0);
    checkOutput("pre_reset_col", col_sel, 0);
    applyStimulus(0, 0, 1, 0);
    tick();
    checkOutput("mid_check_state", state, 3);
    reset = 1;
    tick();
    reset = 0;
    checkOutput("mid_reset_state", state, 0);
    checkOutput("mid_reset_board", board_flat, 0);
    clearModel();
    scur = 0;
    tick();

    // Anti-diagonal P2 win ending at (2,6).
    dropAt(0, 4, 1);
    dropAt(3, 4, 1);
    dropAt(4, 4, 1);
    dropAt(4, 4, 1);
    dropAt(5, 4, 1);
    dropAt(6, 4, 1);
    dropAt(5, 4, 1);
    dropAt(5, 4, 1);
    dropAt(6, 4, 1);
    dropAt(0, 4, 1);
    dropAt(6, 4, 1);
    dropAt(6, 4, 0);
    checkOutput("anti_winner", winner, 2'b10);
    checkOutput("anti_state", state, 5);
    checkOutput("anti_last", {last_row, last_col}, {3'd2, 3'd6});

    // Small board fills with no line of three.
    checkOutput("small_ready", s_state, 1);
    smallDrop(0, 1);
    smallDrop(1, 1);
    smallDrop(2, 1);
    smallDrop(0, 1);
    smallDrop(1, 1);
    smallDrop(2, 5);
    checkOutput("small_draw", s_draw, 1);
    checkOutput("small_winner", s_winner, 0);
    checkOutput("small_game_over", s_game_over, 1);
    checkOutput("small_board", s_board, 12'h666);
    smallStimulus(0, 0, 1);
    checkOutput("small_restart_state", s_state, 0);
    checkOutput("small_restart_board", s_board, 0);
    checkOutput("small_restart_draw", s_draw, 0);
    tick();
    checkOutput("small_restart_play", s_state, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
